// File: rtl/salsa_pkg.sv
// Shared types and constants for the Salsa20/r round controller.
// Feed-forward cycle is enabled by defining SALSA_CTRL_FEEDFORWARD_EN.
package salsa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } salsa_state_e;

    localparam int unsigned SALSA20_8_DROUNDS = 4;

    // Counter width covering half-rounds 0..2*ndr-1, never narrower than one bit.
    function automatic int unsigned salsa_cnt_w(input int unsigned ndr);
        int unsigned w;
        w = $clog2(2 * ndr);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/salsa_round_ctrl_if.sv
// Handshake and datapath-control bundle between a requester and salsa_round_ctrl.
interface salsa_round_ctrl_if
    import salsa_pkg::*;
#(
    parameter int unsigned NUM_DROUNDS = SALSA20_8_DROUNDS
);
    localparam int unsigned CNT_W = salsa_cnt_w(NUM_DROUNDS);

    logic             init;
    logic             abort;
    logic             write_temp;
    logic             sel_in;
    logic             sel_order;
    logic [CNT_W-1:0] round_cnt;
    logic             add_en;
    logic             busy;
    logic             valid;

    modport master (
        output init, abort,
        input  write_temp, sel_in, sel_order, round_cnt, add_en, busy, valid
    );

    modport slave (
        input  init, abort,
        output write_temp, sel_in, sel_order, round_cnt, add_en, busy, valid
    );
endinterface

// File: rtl/salsa_round_cnt.sv
// Half-round counter with synchronous clear, enable and terminal-count flag.
module salsa_round_cnt
    import salsa_pkg::*;
#(
    parameter int unsigned NUM_DROUNDS = SALSA20_8_DROUNDS
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  clr,
    input  logic                                  en,
    output logic [salsa_cnt_w(NUM_DROUNDS)-1:0]   cnt,
    output logic                                  tc
);
    localparam int unsigned CNT_W = salsa_cnt_w(NUM_DROUNDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * NUM_DROUNDS - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == LAST);
endmodule

// File: rtl/salsa_round_ctrl.sv
// Round-sequencing controller for one Salsa20/r datapath (Moore outputs).
// Define SALSA_CTRL_FEEDFORWARD_EN to add the FINAL feed-forward cycle.
module salsa_round_ctrl
    import salsa_pkg::*;
#(
    parameter int unsigned NUM_DROUNDS = SALSA20_8_DROUNDS
) (
    input  logic              clk,
    input  logic              reset_n,
    salsa_round_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = salsa_cnt_w(NUM_DROUNDS);

    salsa_state_e     state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;
    logic             cnt_clr;
    logic             cnt_en;

    salsa_round_cnt #(.NUM_DROUNDS(NUM_DROUNDS)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .cnt     (cnt),
        .tc      (cnt_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = IDLE;
        cnt_clr        = 1'b1;
        cnt_en         = 1'b0;
        bus.write_temp = 1'b0;
        bus.sel_in     = 1'b0;
        bus.sel_order  = 1'b0;
        bus.round_cnt  = '0;
        bus.add_en     = 1'b0;
        bus.busy       = 1'b0;
        bus.valid      = 1'b0;

        case (state)
            IDLE: begin
                bus.write_temp = 1'b1;
                // The start cycle itself is half-round 0, so the counter leaves IDLE at 1.
                if (!bus.abort && bus.init) begin
                    state_nx = ROUND;
                    cnt_clr  = 1'b0;
                    cnt_en   = 1'b1;
                end
            end
            ROUND: begin
                bus.write_temp = 1'b1;
                bus.sel_in     = 1'b1;
                bus.sel_order  = cnt[0];
                bus.round_cnt  = cnt;
                bus.busy       = 1'b1;
                if (bus.abort) begin
                    state_nx = IDLE;
                end else if (cnt_tc) begin
`ifdef SALSA_CTRL_FEEDFORWARD_EN
                    state_nx = FINAL;
`else
                    state_nx = DONE;
`endif
                end else begin
                    state_nx = ROUND;
                    cnt_clr  = 1'b0;
                    cnt_en   = 1'b1;
                end
            end
`ifdef SALSA_CTRL_FEEDFORWARD_EN
            FINAL: begin
                bus.write_temp = 1'b1;
                bus.sel_in     = 1'b1;
                bus.sel_order  = 1'b1;
                bus.add_en     = 1'b1;
                bus.busy       = 1'b1;
                state_nx       = bus.abort ? IDLE : DONE;
            end
`endif
            DONE: begin
                bus.sel_in = 1'b1;
                bus.valid  = 1'b1;
                state_nx   = (bus.init && !bus.abort) ? DONE : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_salsa_round_ctrl.sv
// Self-checking bench: three controllers (N=1,4,16) against a step-count reference model.
module tb_salsa_round_ctrl;

`ifdef SALSA_CTRL_FEEDFORWARD_EN
    localparam int FF = 1;
`else
    localparam int FF = 0;
`endif
    localparam int NS [3] = '{1, 4, 16};
    localparam logic [10:0] IDLE_VEC = 11'b100_00000_000;

    logic clk;
    logic reset_n;
    logic init_v  [3];
    logic abort_v [3];
    logic [10:0] obs [3];

    int errors = 0;
    int checks = 0;
    int st  [3];
    int lat [3];
    int lat2;

    salsa_round_ctrl_if #(.NUM_DROUNDS(1))  i0 ();
    salsa_round_ctrl_if #(.NUM_DROUNDS(4))  i1 ();
    salsa_round_ctrl_if #(.NUM_DROUNDS(16)) i2 ();

    assign i0.init = init_v[0];  assign i0.abort = abort_v[0];
    assign i1.init = init_v[1];  assign i1.abort = abort_v[1];
    assign i2.init = init_v[2];  assign i2.abort = abort_v[2];

    assign obs[0] = {i0.write_temp, i0.sel_in, i0.sel_order, 5'(i0.round_cnt), i0.add_en, i0.busy, i0.valid};
    assign obs[1] = {i1.write_temp, i1.sel_in, i1.sel_order, 5'(i1.round_cnt), i1.add_en, i1.busy, i1.valid};
    assign obs[2] = {i2.write_temp, i2.sel_in, i2.sel_order, 5'(i2.round_cnt), i2.add_en, i2.busy, i2.valid};

    salsa_round_ctrl #(.NUM_DROUNDS(1))  u_n1  (.clk(clk), .reset_n(reset_n), .bus(i0));
    salsa_round_ctrl #(.NUM_DROUNDS(4))  u_n4  (.clk(clk), .reset_n(reset_n), .bus(i1));
    salsa_round_ctrl #(.NUM_DROUNDS(16)) u_n16 (.clk(clk), .reset_n(reset_n), .bus(i2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model step s: 0 idle, 1..2n-1 half-rounds, 2n feed-forward (if enabled), 2n+FF done.
    function automatic logic [10:0] decode(input int s, input int n);
        logic [4:0] rc;
        rc = 5'(s);
        if (s == 0)              return IDLE_VEC;
        else if (s < 2 * n)      return {1'b1, 1'b1, rc[0], rc, 1'b0, 1'b1, 1'b0};
        else if (s < 2 * n + FF) return {1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0};
        else                     return {1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1};
    endfunction

    function automatic int next_step(input int s, input int n, input logic ini, input logic abt);
        int last;
        last = 2 * n + FF;
        if (abt)           return 0;
        if (s == 0)        return ini ? 1 : 0;
        if (s < last)      return s + 1;
        return ini ? last : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < 3; d++)
            chk($sformatf("%s_n%0d", tag, NS[d]), 32'(obs[d]), 32'(decode(st[d], NS[d])));
    endtask

    // Inputs are set at the falling edge; one tick = sampling edge, model update, check.
    task automatic tick(input string tag);
        @(posedge clk);
        for (int d = 0; d < 3; d++)
            st[d] = next_step(st[d], NS[d], init_v[d], abort_v[d]);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic set_all(input logic ini, input logic abt);
        for (int d = 0; d < 3; d++) begin
            init_v[d]  = ini;
            abort_v[d] = abt;
        end
    endtask

    initial begin
        set_all(1'b0, 1'b0);
        for (int d = 0; d < 3; d++) st[d] = 0;
        reset_n = 1'b0;
        #12;
        for (int d = 0; d < 3; d++) chk($sformatf("reset_n%0d", NS[d]), 32'(obs[d]), 32'(IDLE_VEC));
        @(negedge clk);
        reset_n = 1'b1;
        tick("idle");

        // Latency: hold init from cycle 0 until every instance reports valid.
        for (int d = 0; d < 3; d++) lat[d] = -1;
        set_all(1'b1, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            tick("run1");
            for (int d = 0; d < 3; d++)
                if (obs[d][0] && lat[d] < 0) lat[d] = c;
        end
        for (int d = 0; d < 3; d++)
            chk($sformatf("latency_n%0d", NS[d]), 32'(lat[d]), 32'(2 * NS[d] + FF));
        set_all(1'b0, 1'b0);
        tick("drop");
        for (int d = 0; d < 3; d++) chk($sformatf("valid_fall_n%0d", NS[d]), 32'(obs[d][0]), 32'd0);

        // Abort at cycle 3 with init dropped: back in IDLE at cycle 4.
        set_all(1'b1, 1'b0);
        repeat (3) tick("pre_abort");
        set_all(1'b0, 1'b1);
        tick("abort");
        chk("abort_busy_n4", 32'(obs[1][1]), 32'd0);
        chk("abort_idle_n16", 32'(obs[2]), 32'(IDLE_VEC));
        set_all(1'b0, 1'b0);
        repeat (3) tick("post_abort");

        // abort together with init in IDLE: no start.
        set_all(1'b1, 1'b1);
        tick("abort_init");
        for (int d = 0; d < 3; d++) chk($sformatf("abort_init_idle_n%0d", NS[d]), 32'(obs[d]), 32'(IDLE_VEC));
        set_all(1'b0, 1'b0);
        tick("idle2");

        // N=4: hold init 5 cycles in DONE, drop for one cycle, restart.
        init_v[1] = 1'b1;
        lat[1] = -1;
        for (int c = 1; c <= 8 + FF + 5; c++) begin
            tick("hold");
            if (obs[1][0] && lat[1] < 0) lat[1] = c;
        end
        chk("hold_no_retrigger_n4", 32'(obs[1]), 32'(decode(2 * 4 + FF, 4)));
        init_v[1] = 1'b0;
        tick("hold_drop");
        chk("hold_valid_fall_n4", 32'(obs[1][0]), 32'd0);
        init_v[1] = 1'b1;
        lat2 = -1;
        for (int c = 1; c <= 20; c++) begin
            tick("rerun");
            if (obs[1][0] && lat2 < 0) lat2 = c;
        end
        chk("rerun_latency_n4", 32'(lat2), 32'(lat[1]));
        init_v[1] = 1'b0;
        tick("idle3");

        // Asynchronous reset in the middle of the half-rounds.
        set_all(1'b1, 1'b0);
        repeat (3) tick("pre_reset");
        #2;
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("async_reset_n%0d", NS[d]), 32'(obs[d]), 32'(IDLE_VEC));
        for (int d = 0; d < 3; d++) st[d] = 0;
        set_all(1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick("post_reset");

        // Random init/abort traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 3; d++) begin
                init_v[d]  = ($urandom_range(0, 3) != 0);
                abort_v[d] = ($urandom_range(0, 29) == 0);
            end
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
